fsm_seq: RTL and testbench

Parametrised multi-stage sequence FSM, the next-generation replacement for the fixed four-state controller. It walks a chain of NUM_STAGES stages, advancing on a per-stage input bit. With the timeout feature compiled in, it can wait a bounded number of cycles per stage. It provides one-hot stage outputs, a completion pulse, a drop/timeout error pulse and a saturating match counter, and sits between input qualifiers and downstream control logic.

---
 rtl/fsm_seq_pkg.sv | 22 ++
 rtl/fsm_seq_timer.sv | 27 ++
 rtl/fsm_seq.sv | 113 +++++++++++
 tb/tb_fsm_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the fsm_seq stage-sequence controller.
// Stage 0 is IDLE; stages 1..NUM_STAGES are the active chain.
package fsm_seq_pkg;

  localparam int unsigned STAGE_IDLE = 0;
  localparam int unsigned MAX_STAGES = 32;

  // Bits needed to hold a stage index covering IDLE plus num_stages stages.
  function automatic int unsigned stage_width(input int unsigned num_stages);
    return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
  endfunction

  // Stage k lights bit k-1; IDLE decodes to all-zero.
  function automatic logic [MAX_STAGES-1:0] stage_onehot(input int unsigned stage);
    logic [MAX_STAGES-1:0] v;
    v = '0;
    if (stage != STAGE_IDLE && stage <= MAX_STAGES)
      v = MAX_STAGES'(1) << (stage - 1);
    return v;
  endfunction

endpackage

// File: rtl/fsm_seq_timer.sv
// Per-stage wait counter for fsm_seq; expired marks the last allowed wait cycle.
// Saturates at TIMEOUT-1 so it never wraps if inc is held past expiry.
module fsm_seq_timer #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (inc && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/fsm_seq.sv
// Multi-stage sequence FSM: advances on in[k], drops or times out to IDLE.
// Build with FSM_TIMEOUT_EN to allow up to TIMEOUT enabled wait cycles per stage.
module fsm_seq
  import fsm_seq_pkg::*;
#(
  parameter  int NUM_STAGES = 3,
  parameter  int TIMEOUT    = 4,
  parameter  int CNT_WIDTH  = 8,
  localparam int SW         = stage_width(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] in,
  output logic [NUM_STAGES-1:0] out,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic [SW-1:0]         state_dbg
);

  if (NUM_STAGES < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("fsm_seq: NUM_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  localparam logic [SW-1:0] S_IDLE = SW'(STAGE_IDLE);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_STAGES);

  logic [SW-1:0]        state_q, state_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [NUM_STAGES:0]  in_ext;
  logic                 cur_in;
  logic                 complete;

  // in[0] qualifies IDLE, in[k] qualifies stage k; the last stage needs no bit.
  assign in_ext   = {1'b0, in};
  assign cur_in   = in_ext[state_q];
  assign complete = en && !abort && (state_q == S_LAST);

`ifdef FSM_TIMEOUT_EN
  logic wait_inc, wait_clear, expired;

  // Any stage change (including abort) restarts the wait budget.
  assign wait_clear = abort || (state_d != state_q);

  fsm_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .inc     (wait_inc),
    .expired (expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (complete && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
`ifdef FSM_TIMEOUT_EN
    wait_inc = 1'b0;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else if (en) begin
      if (state_q == S_IDLE) begin
        if (cur_in) state_d = state_q + 1'b1;
      end else if (state_q == S_LAST) begin
        state_d = S_IDLE;
      end else if (cur_in) begin
        state_d = state_q + 1'b1;
      end else begin
`ifdef FSM_TIMEOUT_EN
        if (expired) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
`else
        state_d = S_IDLE;
        err_d   = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    out       = NUM_STAGES'(stage_onehot(32'(state_q)));
    done      = (state_q == S_LAST);
    err       = err_q;
    match_cnt = cnt_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_fsm_seq.sv
// Directed bench for fsm_seq (NUM_STAGES=3, TIMEOUT=4, CNT_WIDTH=2).
// Timeout expectations follow whether FSM_TIMEOUT_EN is defined for the build.
module tb_fsm_seq;

  logic       clk = 1'b0;
  logic       rst, en, abort;
  logic [2:0] in_bits;
  logic [2:0] out;
  logic       done, err;
  logic [1:0] match_cnt;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  fsm_seq #(.NUM_STAGES(3), .TIMEOUT(4), .CNT_WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .abort     (abort),
    .in        (in_bits),
    .out       (out),
    .done      (done),
    .err       (err),
    .match_cnt (match_cnt),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic a, input logic [2:0] i);
    en = e; abort = a; in_bits = i;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [2:0] o, input logic d,
                            input logic e, input logic [1:0] c);
    chk({tag, ".out"}, 32'(out), 32'(o));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".cnt"}, 32'(match_cnt), 32'(c));
  endtask

  task automatic run_seq(input string tag, input logic [1:0] c0, input logic [1:0] c1);
    drive(1, 0, 3'b001); tick(); expect_all({tag, ".s1"}, 3'b001, 0, 0, c0);
    drive(1, 0, 3'b010); tick(); expect_all({tag, ".s2"}, 3'b010, 0, 0, c0);
    drive(1, 0, 3'b100); tick(); expect_all({tag, ".s3"}, 3'b100, 1, 0, c0);
    drive(1, 0, 3'b000); tick(); expect_all({tag, ".idle"}, 3'b000, 0, 0, c1);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 3'b000);
    tick(); tick();
    expect_all("reset", 3'b000, 0, 0, 2'd0);
    rst = 1'b0;
    tick();
    expect_all("post_reset", 3'b000, 0, 0, 2'd0);

    run_seq("seq1", 2'd0, 2'd1);

    // Stall in stage 1 with no qualifying input.
    drive(1, 0, 3'b001); tick(); expect_all("to.enter", 3'b001, 0, 0, 2'd1);
    drive(1, 0, 3'b000);
`ifdef FSM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick(); expect_all("to.wait", 3'b001, 0, 0, 2'd1);
    end
`endif
    tick(); expect_all("to.expire", 3'b000, 0, 1, 2'd1);
    tick(); expect_all("to.err_clear", 3'b000, 0, 0, 2'd1);

    // Advance on the last allowed wait cycle.
    drive(1, 0, 3'b001); tick(); expect_all("late.enter", 3'b001, 0, 0, 2'd1);
`ifdef FSM_TIMEOUT_EN
    drive(1, 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_all("late.wait", 3'b001, 0, 0, 2'd1);
    end
`endif
    drive(1, 0, 3'b010); tick(); expect_all("late.adv", 3'b010, 0, 0, 2'd1);

    // Freeze in stage 2 with en low.
    drive(0, 0, 3'b000);
    for (int i = 0; i < 10; i++) begin
      tick(); expect_all("freeze", 3'b010, 0, 0, 2'd1);
    end
    drive(1, 0, 3'b100); tick(); expect_all("freeze.adv", 3'b100, 1, 0, 2'd1);
    drive(1, 0, 3'b000); tick(); expect_all("freeze.done", 3'b000, 0, 0, 2'd2);

    // Abort from stage 2, with en low to show abort overrides gating.
    drive(1, 0, 3'b001); tick(); expect_all("abort.s1", 3'b001, 0, 0, 2'd2);
    drive(1, 0, 3'b010); tick(); expect_all("abort.s2", 3'b010, 0, 0, 2'd2);
    drive(0, 1, 3'b100); tick(); expect_all("abort", 3'b000, 0, 0, 2'd2);
    drive(1, 0, 3'b000); tick(); expect_all("abort.after", 3'b000, 0, 0, 2'd2);

    run_seq("sat3", 2'd2, 2'd3);
    run_seq("sat4", 2'd3, 2'd3);
    run_seq("sat5", 2'd3, 2'd3);

    // Reset while in the final stage.
    drive(1, 0, 3'b001); tick();
    drive(1, 0, 3'b010); tick();
    drive(1, 0, 3'b100); tick(); expect_all("rst.s3", 3'b100, 1, 0, 2'd3);
    rst = 1'b1; drive(1, 0, 3'b000);
    tick(); expect_all("rst.mid", 3'b000, 0, 0, 2'd0);
    rst = 1'b0;
    tick(); expect_all("rst.after", 3'b000, 0, 0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
